scene_fade_mixer: RTL and testbench
===================================

Name: scene_fade_mixer

Overview:
- Downstream consumer of the scene-change dot generator's output FIFO and of the base-layer dot FIFO.
- Pops both streams in lockstep and keys the overlay over the base.
- Applies a frame-stepped fade level to base-layer pixels only.
- Pushes composited RGB565 pixels into the display-side FIFO. A fade FSM sequences fade-out, hold and fade-in over frames and flags the mid-point so scene data can be swapped.

Parameters:
- pColorDepth, 16: pixel width; RGB565 layout fixed ([15:11] R, [10:5] G, [4:0] B).
- pHoldWidth, 8: width of the hold-frame counter and of iHoldFrames.

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset, synchronous, active-high
- iFe  in  1  frame-end pulse, 1 cycle per frame
- iFadeStart  in  1  start fade sequence; honoured only in IDLE
- iFadeStep  in  5  level change per frame; 0 treated as 1
- iHoldFrames  in  pHoldWidth  frames to stay black
- iTransColor  in  pColorDepth  overlay transparent key
- iBaseVdd  in  1  base FIFO read-data valid
- iBaseDd  in  pColorDepth  base FIFO read data
- iBaseEmp  in  1  base FIFO empty
- oBaseEdd  out  1  base FIFO read enable
- iOvlVdd  in  1  overlay FIFO read-data valid
- iOvlDd  in  pColorDepth  overlay FIFO read data
- iOvlEmp  in  1  overlay FIFO empty
- oOvlEdd  out  1  overlay FIFO read enable
- iFull  in  1  downstream almost-full; asserted with at least 2 free entries
- oVd  out  1  output pixel write enable
- oDd  out  pColorDepth  output pixel
- oLevel  out  5  current fade level, 0..16
- oBusy  out  1  FSM not in IDLE
- oSceneMid  out  1  1-cycle pulse on entry to HOLD
- oErr  out  1  sticky protocol error

Behaviour:
- Reset values: oBaseEdd=0, oOvlEdd=0, oVd=0, oDd=0, oLevel=16, oBusy=0, oSceneMid=0, oErr=0, FSM=IDLE, hold counter=0.
- Read issue:
  - oBaseEdd = oOvlEdd = !iBaseEmp && !iOvlEmp && !iFull && !iRst. This is combinational and identical for both.
  - Never pop only one FIFO.
- Pipeline, read at cycle T:
  - FIFOs return data with Vdd at T+1.
  - Output register updates at T+2: oVd=1, oDd=mix.
  - Latency: 2 cycles from read enable to oVd.
  - Throughput: 1 pixel per cycle.
  - Up to 2 pixels may still be in flight after iFull rises; the downstream margin covers them.
- Mix:
  - If iOvlDd != iTransColor, output iOvlDd unchanged (overlay is not faded).
  - Otherwise output the base pixel scaled per channel: c' = (c*oLevel)>>4, 10/11-bit product truncated, repacked RGB565.
  - oLevel=16 passes base unchanged; oLevel=0 gives 0x0000.
  - oLevel is sampled at the T+1 stage.
- oErr is set, and held until reset, if iBaseVdd != iOvlVdd in any cycle, or if either Vdd is asserted without a read issued in the previous cycle. When a mismatch occurs, oVd stays 0 for that slot.
- FSM IDLE:
  - Level held at 16.
  - iFadeStart -> FADE_OUT, oBusy=1 next cycle.
  - An iFe in the same cycle as iFadeStart causes no level change.
- FSM FADE_OUT:
  - On each iFe: level = max(level - step, 0).
  - When the new level is 0 -> HOLD, load counter = iHoldFrames, pulse oSceneMid for 1 cycle.
- FSM HOLD:
  - On each iFe: if counter==0 -> FADE_IN, else counter--.
  - iHoldFrames=0 leaves HOLD on the first iFe.
- FSM FADE_IN:
  - On each iFe: level = min(level + step, 16).
  - When the new level is 16 -> IDLE, oBusy=0.
- iFadeStart outside IDLE is ignored.
- oLevel changes only in the cycle after an iFe.
- Reset mid-fade: everything returns to reset values in the next cycle. In-flight pixels are discarded (oVd=0) and no partial pixel is emitted.

Test Plan:
1. Streaming, IDLE:
   - Stimulus: both FIFOs hold 4 pixels; base=0xFFFF, overlay=iTransColor=0xF81F; iFull=0.
   - Required: Edd high 4 cycles; 4 outputs 0xFFFF starting 2 cycles after the first read; then Edd=0 once both are empty.
2. Overlay key:
   - Stimulus: overlay=0x07E0, base=0x1234.
   - Required: output 0x07E0 at any oLevel.
3. Fade-out math:
   - Stimulus: step=4, base=0xFFFF, pulse start, then 2 iFe.
   - Required: oLevel 12 then 8.
   - At level 8, pixel=0x7BEF (R 15, G 31, B 15).
4. Full sequence:
   - Stimulus: step=5, hold=2, start, then iFe pulses.
   - Required: levels 16→11→6→1→0.
   - oSceneMid pulses once on entry to 0.
   - 3 iFe pulses in HOLD.
   - Then 5→10→15→16, oBusy drops.
   - Start during the sequence is ignored.
5. Backpressure and empty:
   - Stimulus: raise iFull mid-stream; separately, make only the overlay FIFO empty.
   - Required: Edd drops in the same cycle as iFull; at most 2 further oVd pulses.
   - With the overlay empty, neither FIFO is read and the base count is unchanged.
6. Error and reset:
   - Stimulus: assert iBaseVdd without iOvlVdd.
   - Required: oErr=1 and stays set.
   - Assert iRst during FADE_OUT at level 6: next cycle oLevel=16, oBusy=0, oErr=0, oVd=0.

Source files
------------

// File: rtl/scene_fade_mixer.sv
// Pops the base and overlay dot FIFOs in lockstep, keys the overlay over a faded base
// and pushes RGB565 pixels downstream; a frame-stepped FSM sequences fade-out/hold/fade-in.
//   state       | meaning
//   ST_IDLE     | level parked at 16, waiting for iFadeStart
//   ST_FADE_OUT | level drops by step on each iFe until it reaches 0
//   ST_HOLD     | screen black, counting iFe pulses down from iHoldFrames
//   ST_FADE_IN  | level rises by step on each iFe until it reaches 16
`timescale 1ns/1ps
module scene_fade_mixer #(
  parameter int pColorDepth = 16,
  parameter int pHoldWidth  = 8
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iFe,
  input  logic                   iFadeStart,
  input  logic [4:0]             iFadeStep,
  input  logic [pHoldWidth-1:0]  iHoldFrames,
  input  logic [pColorDepth-1:0] iTransColor,
  input  logic                   iBaseVdd,
  input  logic [pColorDepth-1:0] iBaseDd,
  input  logic                   iBaseEmp,
  output logic                   oBaseEdd,
  input  logic                   iOvlVdd,
  input  logic [pColorDepth-1:0] iOvlDd,
  input  logic                   iOvlEmp,
  output logic                   oOvlEdd,
  input  logic                   iFull,
  output logic                   oVd,
  output logic [pColorDepth-1:0] oDd,
  output logic [4:0]             oLevel,
  output logic                   oBusy,
  output logic                   oSceneMid,
  output logic                   oErr
);

  localparam logic [4:0] LVL_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [4:0]              r_level;
  logic [pHoldWidth-1:0]   r_hold_cnt;
  logic                    r_busy;
  logic                    r_scene_mid;
  logic                    r_rd_d;
  logic                    r_vd;
  logic [pColorDepth-1:0]  r_dd;
  logic                    r_err;

  logic                    w_rd;
  logic [4:0]              w_step;
  logic [5:0]              w_lvl_up;
  logic [4:0]              w_r_sc;
  logic [5:0]              w_g_sc;
  logic [4:0]              w_b_sc;
  logic [pColorDepth-1:0]  w_scaled;
  logic [pColorDepth-1:0]  w_mix;
  logic                    w_pix_ok;
  logic                    w_proto_err;

  // Both FIFOs are always popped together so the streams can never slip.
  assign w_rd     = !iBaseEmp && !iOvlEmp && !iFull && !iRst;
  assign oBaseEdd = w_rd;
  assign oOvlEdd  = w_rd;

  assign w_step   = (iFadeStep == 5'd0) ? 5'd1 : iFadeStep;
  assign w_lvl_up = {1'b0, r_level} + {1'b0, w_step};

  // Per-channel scale by level/16; products cannot exceed the channel width at level 16.
  assign w_r_sc   = 5'(({5'b0, iBaseDd[15:11]} * {5'b0, r_level}) >> 4);
  assign w_g_sc   = 6'(({5'b0, iBaseDd[10:5]}  * {6'b0, r_level}) >> 4);
  assign w_b_sc   = 5'(({5'b0, iBaseDd[4:0]}   * {5'b0, r_level}) >> 4);
  assign w_scaled = {w_r_sc, w_g_sc, w_b_sc};
  assign w_mix    = (iOvlDd != iTransColor) ? iOvlDd : w_scaled;

  assign w_pix_ok    = iBaseVdd && iOvlVdd && r_rd_d;
  assign w_proto_err = (iBaseVdd != iOvlVdd) || ((iBaseVdd || iOvlVdd) && !r_rd_d);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rd_d <= 1'b0;
      r_vd   <= 1'b0;
      r_dd   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_rd_d <= w_rd;
      r_vd   <= w_pix_ok;
      if (w_pix_ok)    r_dd  <= w_mix;
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= ST_IDLE;
      r_level     <= LVL_MAX;
      r_hold_cnt  <= '0;
      r_busy      <= 1'b0;
      r_scene_mid <= 1'b0;
    end else begin
      r_scene_mid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_level <= LVL_MAX;
          if (iFadeStart) begin
            r_state <= ST_FADE_OUT;
            r_busy  <= 1'b1;
          end
        end
        ST_FADE_OUT: begin
          if (iFe) begin
            if (r_level <= w_step) begin
              r_level     <= 5'd0;
              r_hold_cnt  <= iHoldFrames;
              r_scene_mid <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_level <= r_level - w_step;
            end
          end
        end
        ST_HOLD: begin
          if (iFe) begin
            if (r_hold_cnt == '0) r_state <= ST_FADE_IN;
            else                  r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        ST_FADE_IN: begin
          if (iFe) begin
            if (w_lvl_up >= 6'd16) begin
              r_level <= LVL_MAX;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_level <= w_lvl_up[4:0];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oVd       = r_vd;
  assign oDd       = r_dd;
  assign oLevel    = r_level;
  assign oBusy     = r_busy;
  assign oSceneMid = r_scene_mid;
  assign oErr      = r_err;

endmodule

// File: tb/tb_scene_fade_mixer.sv
// Directed bench for scene_fade_mixer: small FIFO models feed both streams,
// each step checks outputs against hand-computed values with immediate assertions.
`timescale 1ns/1ps
module tb_scene_fade_mixer;

  logic        iClk = 1'b0;
  logic        iRst, iFe, iFadeStart, iFull;
  logic [4:0]  iFadeStep;
  logic [7:0]  iHoldFrames;
  logic [15:0] iTransColor;
  logic        iBaseVdd, iBaseEmp, oBaseEdd, iOvlVdd, iOvlEmp, oOvlEdd;
  logic [15:0] iBaseDd, iOvlDd;
  logic        oVd, oBusy, oSceneMid, oErr;
  logic [15:0] oDd;
  logic [4:0]  oLevel;

  logic [15:0] bmem [0:63];
  logic [15:0] omem [0:63];
  int          b_wr = 0, b_rd = 0, o_wr = 0, o_rd = 0;
  logic        fb_vdd = 1'b0, fo_vdd = 1'b0;
  logic [15:0] fb_dd = '0, fo_dd = '0;
  logic        inj_b = 1'b0;

  int total = 0;
  int bad   = 0;
  int pre_n, post_n, drain_n;

  always #5 iClk = ~iClk;

  assign iBaseEmp = (b_wr == b_rd);
  assign iOvlEmp  = (o_wr == o_rd);
  assign iBaseVdd = fb_vdd | inj_b;
  assign iOvlVdd  = fo_vdd;
  assign iBaseDd  = fb_dd;
  assign iOvlDd   = fo_dd;

  // FIFO models: read data valid one cycle after the read enable is sampled
  always @(posedge iClk) begin
    fb_vdd <= 1'b0;
    fo_vdd <= 1'b0;
    if (oBaseEdd && (b_wr != b_rd)) begin
      fb_dd  <= bmem[b_rd % 64];
      fb_vdd <= 1'b1;
      b_rd   <= b_rd + 1;
    end
    if (oOvlEdd && (o_wr != o_rd)) begin
      fo_dd  <= omem[o_rd % 64];
      fo_vdd <= 1'b1;
      o_rd   <= o_rd + 1;
    end
  end

  scene_fade_mixer #(.pColorDepth(16), .pHoldWidth(8)) dut (
    .iClk(iClk), .iRst(iRst), .iFe(iFe), .iFadeStart(iFadeStart),
    .iFadeStep(iFadeStep), .iHoldFrames(iHoldFrames), .iTransColor(iTransColor),
    .iBaseVdd(iBaseVdd), .iBaseDd(iBaseDd), .iBaseEmp(iBaseEmp), .oBaseEdd(oBaseEdd),
    .iOvlVdd(iOvlVdd), .iOvlDd(iOvlDd), .iOvlEmp(iOvlEmp), .oOvlEdd(oOvlEdd),
    .iFull(iFull), .oVd(oVd), .oDd(oDd), .oLevel(oLevel), .oBusy(oBusy),
    .oSceneMid(oSceneMid), .oErr(oErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_b(input logic [15:0] v);
    bmem[b_wr % 64] = v;
    b_wr = b_wr + 1;
  endtask

  task automatic push_o(input logic [15:0] v);
    omem[o_wr % 64] = v;
    o_wr = o_wr + 1;
  endtask

  task automatic fe_pulse();
    @(negedge iClk); iFe = 1'b1;
    @(negedge iClk); iFe = 1'b0;
    #1;
  endtask

  // Push n pixel pairs in one cycle, then watch reads and outputs.
  task automatic stream(input int n, input logic [15:0] b, input logic [15:0] o,
                        input logic [15:0] exp, input string tag);
    int edd_n, vd_n, first_vd;
    edd_n = 0; vd_n = 0; first_vd = -1;
    @(negedge iClk);
    for (int k = 0; k < n; k++) begin
      push_b(b);
      push_o(o);
    end
    #1;
    for (int i = 0; i < n + 6; i++) begin
      if (i > 0) begin @(negedge iClk); #1; end
      if (oBaseEdd) edd_n++;
      if (oBaseEdd != oOvlEdd) chk({tag, "_edd_pair"}, {31'd0, oOvlEdd}, {31'd0, oBaseEdd});
      if (oVd) begin
        vd_n++;
        if (first_vd < 0) first_vd = i;
        chk({tag, "_dd"}, {16'd0, oDd}, {16'd0, exp});
      end
    end
    chk({tag, "_edd_cycles"}, edd_n, n);
    chk({tag, "_vd_count"}, vd_n, n);
    chk({tag, "_latency"}, first_vd, 2);
    chk({tag, "_edd_idle"}, {31'd0, oBaseEdd}, 32'd0);
  endtask

  initial begin
    iRst = 1'b1; iFe = 1'b0; iFadeStart = 1'b0; iFull = 1'b0;
    iFadeStep = 5'd0; iHoldFrames = 8'd0; iTransColor = 16'hF81F;
    repeat (2) @(negedge iClk);
    #1;
    chk("rst_vd",    {31'd0, oVd},       32'd0);
    chk("rst_dd",    {16'd0, oDd},       32'd0);
    chk("rst_level", {27'd0, oLevel},    32'd16);
    chk("rst_busy",  {31'd0, oBusy},     32'd0);
    chk("rst_mid",   {31'd0, oSceneMid}, 32'd0);
    chk("rst_err",   {31'd0, oErr},      32'd0);
    chk("rst_edd",   {31'd0, oBaseEdd},  32'd0);
    @(negedge iClk); iRst = 1'b0;

    stream(4, 16'hFFFF, 16'hF81F, 16'hFFFF, "t1_idle");
    stream(2, 16'h1234, 16'h07E0, 16'h07E0, "t2_key16");

    // fade-out math; an iFe coinciding with the start must not move the level
    @(negedge iClk); iFadeStep = 5'd4; iFadeStart = 1'b1; iFe = 1'b1;
    @(negedge iClk); iFadeStart = 1'b0; iFe = 1'b0; #1;
    chk("t3_busy", {31'd0, oBusy}, 32'd1);
    chk("t3_lvl_start", {27'd0, oLevel}, 32'd16);
    fe_pulse(); chk("t3_lvl12", {27'd0, oLevel}, 32'd12);
    fe_pulse(); chk("t3_lvl8",  {27'd0, oLevel}, 32'd8);
    stream(3, 16'hFFFF, 16'hF81F, 16'h7BEF, "t3_half");
    stream(2, 16'h1234, 16'h07E0, 16'h07E0, "t2_key8");
    chk("t3_lvl_hold8", {27'd0, oLevel}, 32'd8);

    @(negedge iClk); iFadeStep = 5'd2;
    fe_pulse(); chk("t6_lvl6", {27'd0, oLevel}, 32'd6);
    @(negedge iClk); inj_b = 1'b1;
    @(negedge iClk); inj_b = 1'b0; #1;
    chk("t6_err_set", {31'd0, oErr}, 32'd1);
    chk("t6_err_novd", {31'd0, oVd}, 32'd0);
    repeat (3) @(negedge iClk);
    #1;
    chk("t6_err_sticky", {31'd0, oErr}, 32'd1);

    // reset with a pixel in flight
    @(negedge iClk); push_b(16'hFFFF); push_o(16'hF81F); push_b(16'hFFFF); push_o(16'hF81F); #1;
    chk("t6_edd_pre", {31'd0, oBaseEdd}, 32'd1);
    @(negedge iClk); iRst = 1'b1; #1;
    chk("t6_edd_in_rst", {31'd0, oBaseEdd}, 32'd0);
    @(negedge iClk); iRst = 1'b0; #1;
    chk("t6_rst_vd",    {31'd0, oVd},    32'd0);
    chk("t6_rst_level", {27'd0, oLevel}, 32'd16);
    chk("t6_rst_busy",  {31'd0, oBusy},  32'd0);
    chk("t6_rst_err",   {31'd0, oErr},   32'd0);
    @(negedge iClk); #1;
    chk("t6_discard_vd", {31'd0, oVd}, 32'd0);
    @(negedge iClk); #1;
    chk("t6_after_vd", {31'd0, oVd}, 32'd1);
    chk("t6_after_dd", {16'd0, oDd}, 32'h0000FFFF);
    @(negedge iClk); #1;
    chk("t6_after_idle", {31'd0, oVd}, 32'd0);

    // full sequence: step 5, hold 2
    @(negedge iClk); iFadeStep = 5'd5; iHoldFrames = 8'd2; iFadeStart = 1'b1;
    @(negedge iClk); iFadeStart = 1'b0; #1;
    chk("t4_busy", {31'd0, oBusy}, 32'd1);
    fe_pulse(); chk("t4_l11", {27'd0, oLevel}, 32'd11);
    chk("t4_mid_early", {31'd0, oSceneMid}, 32'd0);
    fe_pulse(); chk("t4_l6", {27'd0, oLevel}, 32'd6);
    fe_pulse(); chk("t4_l1", {27'd0, oLevel}, 32'd1);
    fe_pulse(); chk("t4_l0", {27'd0, oLevel}, 32'd0);
    chk("t4_mid", {31'd0, oSceneMid}, 32'd1);
    @(negedge iClk); iFadeStart = 1'b1; #1;
    chk("t4_mid_once", {31'd0, oSceneMid}, 32'd0);
    @(negedge iClk); iFadeStart = 1'b0;
    fe_pulse(); chk("t4_hold1", {27'd0, oLevel}, 32'd0);
    fe_pulse(); chk("t4_hold2", {27'd0, oLevel}, 32'd0);
    fe_pulse(); chk("t4_hold3", {27'd0, oLevel}, 32'd0);
    chk("t4_hold_busy", {31'd0, oBusy}, 32'd1);
    fe_pulse(); chk("t4_l5", {27'd0, oLevel}, 32'd5);
    @(negedge iClk); iFadeStart = 1'b1;
    @(negedge iClk); iFadeStart = 1'b0; #1;
    chk("t4_l5_steady", {27'd0, oLevel}, 32'd5);
    fe_pulse(); chk("t4_l10", {27'd0, oLevel}, 32'd10);
    fe_pulse(); chk("t4_l15", {27'd0, oLevel}, 32'd15);
    chk("t4_busy_l15", {31'd0, oBusy}, 32'd1);
    fe_pulse(); chk("t4_l16", {27'd0, oLevel}, 32'd16);
    chk("t4_done_busy", {31'd0, oBusy}, 32'd0);
    fe_pulse(); chk("t4_idle_l16", {27'd0, oLevel}, 32'd16);

    // backpressure
    pre_n = 0; post_n = 0; drain_n = 0;
    @(negedge iClk);
    for (int k = 0; k < 8; k++) begin push_b(16'hFFFF); push_o(16'hF81F); end
    #1;
    chk("t5_edd0", {31'd0, oBaseEdd}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      @(negedge iClk); #1;
      if (oVd) pre_n++;
    end
    @(negedge iClk); iFull = 1'b1; #1;
    chk("t5_edd_full_base", {31'd0, oBaseEdd}, 32'd0);
    chk("t5_edd_full_ovl",  {31'd0, oOvlEdd},  32'd0);
    if (oVd) post_n++;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk); #1;
      if (oVd) post_n++;
    end
    chk("t5_post_le2", {31'd0, (post_n <= 2)}, 32'd1);
    chk("t5_inflight_total", pre_n + post_n, 3);
    chk("t5_base_left", b_wr - b_rd, 5);
    @(negedge iClk); iFull = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk); #1;
      if (oVd) drain_n++;
    end
    chk("t5_drain", drain_n, 5);

    // overlay empty: nothing is popped
    @(negedge iClk); push_b(16'h1111); push_b(16'h2222); push_b(16'h3333); #1;
    chk("t5_ovl_emp_edd", {31'd0, oBaseEdd}, 32'd0);
    repeat (3) @(negedge iClk);
    #1;
    chk("t5_ovl_emp_edd2", {31'd0, oOvlEdd}, 32'd0);
    chk("t5_base_kept", b_wr - b_rd, 3);
    chk("t5_ovl_emp_vd", {31'd0, oVd}, 32'd0);
    drain_n = 0;
    @(negedge iClk); push_o(16'hF81F); push_o(16'hF81F); push_o(16'hF81F);
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk); #1;
      if (oVd) drain_n++;
    end
    chk("t5_ovl_drain", drain_n, 3);
    chk("t5_err_clean", {31'd0, oErr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
